// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: load-use and ID-branch stalls, dmem freeze.
// Optional performance counters are compiled in with `define HAZARD_PERF_EN.
module hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] id_opcode,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_branch_taken,
  input  logic [4:0] ex_rd,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  input  logic [4:0] mem_rd,
  input  logic       mem_mem_read,
  input  logic       dmem_busy,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       id_ex_bubble,
  output logic       pipe_adv,
  output logic [1:0] hz_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_freeze_cnt
`endif
);

  localparam int unsigned OP_W  = 7;
  localparam int unsigned REG_W = 5;

  localparam logic [OP_W-1:0] OP_LUI   = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC = 7'b0010111;
  localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR  = 7'b1100111;
  localparam logic [OP_W-1:0] OP_R     = 7'b0110011;
  localparam logic [OP_W-1:0] OP_S     = 7'b0100011;
  localparam logic [OP_W-1:0] OP_B     = 7'b1100011;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_STALL2 = 2'b01,
    ST_FROZEN = 2'b10
  } state_t;

  state_t state, next_state, eff_state, hz_mode;
  logic   saved, saved_d;

  // Operand-use decode and register match against EX / MEM destinations
  logic uses_rs1, uses_rs2, is_br;
  logic match_ex, match_mem;
  logic need1, need2;

  assign uses_rs1 = (id_opcode != OP_LUI) && (id_opcode != OP_AUIPC) && (id_opcode != OP_JAL);
  assign uses_rs2 = (id_opcode == OP_R) || (id_opcode == OP_S) || (id_opcode == OP_B);
  assign is_br    = (id_opcode == OP_B) || (id_opcode == OP_JALR);

  assign match_ex  = (ex_rd != REG_W'(0)) &&
                     ((uses_rs1 && (id_rs1 == ex_rd)) || (uses_rs2 && (id_rs2 == ex_rd)));
  assign match_mem = (mem_rd != REG_W'(0)) &&
                     ((uses_rs1 && (id_rs1 == mem_rd)) || (uses_rs2 && (id_rs2 == mem_rd)));

  assign need2 = is_br && match_ex && ex_mem_read;
  assign need1 = (is_br && match_ex && ex_reg_write) ||
                 (is_br && match_mem && mem_mem_read) ||
                 (match_ex && ex_mem_read);

  // Leaving FROZEN resumes the saved state in the same cycle
  assign eff_state = (state == ST_FROZEN) ? (saved ? ST_STALL2 : ST_RUN) : state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      saved <= 1'b0;
    end else begin
      state <= next_state;
      saved <= saved_d;
    end
  end

  always_comb begin
    next_state   = ST_RUN;
    saved_d      = saved;
    hz_mode      = ST_RUN;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_adv     = 1'b1;
    if (rst) begin
      saved_d = 1'b0;
    end else if (dmem_busy) begin
      next_state  = ST_FROZEN;
      saved_d     = (eff_state == ST_STALL2);
      hz_mode     = ST_FROZEN;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_adv    = 1'b0;
    end else begin
      // hz_state reports the mode actually applied this cycle
      hz_mode = eff_state;
      case (eff_state)
        ST_RUN: begin
          if (need2 || need1) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            next_state   = need2 ? ST_STALL2 : ST_RUN;
          end else begin
            if_id_flush = id_branch_taken;
          end
        end
        ST_STALL2: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign hz_state = hz_mode;

`ifdef HAZARD_PERF_EN
  // Event counters, free-running with natural wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt  <= 32'd0;
      perf_flush_cnt  <= 32'd0;
      perf_freeze_cnt <= 32'd0;
    end else begin
      if (id_ex_bubble)       perf_stall_cnt  <= perf_stall_cnt + 32'd1;
      if (if_id_flush)        perf_flush_cnt  <= perf_flush_cnt + 32'd1;
      if (state == ST_FROZEN) perf_freeze_cnt <= perf_freeze_cnt + 32'd1;
    end
  end
`endif

endmodule
